// File: rtl/solitaire_pkg.sv
// Shared definitions for the solitaire move controller: card field layout,
// column-bus operation codes, result codes and the sequencer state type.
package solitaire_pkg;

    localparam int CARD_W   = 6;
    localparam int RANK_LSB = 0;
    localparam int RANK_MSB = 3;
    localparam int SUIT_LSB = 4;
    localparam int SUIT_MSB = 5;

    localparam logic [3:0] RANK_EMPTY = 4'hF;
    localparam logic [3:0] RANK_KING  = 4'd13;

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_PEEK = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b11;
    localparam logic [1:0] OP_PUSH = 2'b10;

    localparam logic [1:0] ERR_OK        = 2'b00;
    localparam logic [1:0] ERR_SRC_EMPTY = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL   = 2'b10;
    localparam logic [1:0] ERR_BAD_IDX   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PEEK_SRC = 3'd1,
        ST_PEEK_DST = 3'd2,
        ST_CHECK    = 3'd3,
        ST_POP_SRC  = 3'd4,
        ST_PUSH_DST = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    function automatic logic [3:0] card_rank(input logic [CARD_W-1:0] card);
        return card[RANK_MSB:RANK_LSB];
    endfunction

    // Colour is the suit MSB: 0 = red (hearts/diamonds), 1 = black.
    function automatic logic card_colour(input logic [CARD_W-1:0] card);
        return card[SUIT_MSB];
    endfunction

endpackage

// File: rtl/card_rule_check.sv
// Combinational placement rule for one card onto a tableau column.
// Optional feature macro: SOLITAIRE_FREE_PLACE_EN (bypasses rank/colour rules,
// any non-empty source becomes legal; used for debug and board setup).
module card_rule_check
    import solitaire_pkg::*;
(
    input  logic [CARD_W-1:0] src_card,
    input  logic [CARD_W-1:0] dst_card,
    output logic              legal,
    output logic [1:0]        err
);

`ifdef SOLITAIRE_FREE_PLACE_EN
    // Destination contents are irrelevant in free-place mode.
    logic unused_dst_s;
    assign unused_dst_s = ^dst_card;
`endif

    // Evaluate the move in priority order: empty source first, then placement.
    always_comb begin
        legal = 1'b0;
        err   = ERR_OK;
        if (card_rank(src_card) == RANK_EMPTY) begin
            legal = 1'b0;
            err   = ERR_SRC_EMPTY;
        end else begin
`ifdef SOLITAIRE_FREE_PLACE_EN
            legal = 1'b1;
            err   = ERR_OK;
`else
            if (card_rank(dst_card) == RANK_EMPTY) begin
                if (card_rank(src_card) == RANK_KING) begin
                    legal = 1'b1;
                    err   = ERR_OK;
                end else begin
                    legal = 1'b0;
                    err   = ERR_ILLEGAL;
                end
            end else if ((card_rank(src_card) + 4'd1 == card_rank(dst_card)) &&
                         (card_colour(src_card) != card_colour(dst_card))) begin
                legal = 1'b1;
                err   = ERR_OK;
            end else begin
                legal = 1'b0;
                err   = ERR_ILLEGAL;
            end
`endif
        end
    end

endmodule

// File: rtl/solitaire_move_ctrl.sv
// Single-card tableau move sequencer: peeks source and destination tops,
// checks legality, then pops the source and pushes onto the destination.
// Optional feature macro: SOLITAIRE_FREE_PLACE_EN (handled in card_rule_check).
module solitaire_move_ctrl
    import solitaire_pkg::*;
#(
    parameter int NUM_COLS = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              move_req,
    input  logic [2:0]        src_col,
    input  logic [2:0]        dst_col,
    output logic              move_ready,
    output logic              move_done,
    output logic              move_ok,
    output logic [1:0]        err_code,
    output logic [2:0]        col_sel,
    output logic [1:0]        col_op,
    output logic [CARD_W-1:0] col_card_out,
    input  logic [CARD_W-1:0] col_card_in
);

    state_e            state_r;
    logic [2:0]        src_sel_r;
    logic [2:0]        dst_sel_r;
    logic [CARD_W-1:0] src_card_r;
    logic              idx_bad_s;
    logic              rule_legal_s;
    logic [1:0]        rule_err_s;

    // The destination top card is on col_card_in during CHECK and is
    // judged directly there against the source card captured earlier.
    card_rule_check u_rule (
        .src_card (src_card_r),
        .dst_card (col_card_in),
        .legal    (rule_legal_s),
        .err      (rule_err_s)
    );

    // Reject out-of-range or identical column indices before touching the bus.
    always_comb begin
        idx_bad_s = 1'b0;
        if ((32'(src_col) >= NUM_COLS) || (32'(dst_col) >= NUM_COLS) ||
            (src_col == dst_col)) begin
            idx_bad_s = 1'b1;
        end else begin
            idx_bad_s = 1'b0;
        end
    end

    // Move sequencer; every output is registered and set on entry to its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            move_ready   <= 1'b1;
            move_done    <= 1'b0;
            move_ok      <= 1'b0;
            err_code     <= ERR_OK;
            col_sel      <= 3'd0;
            col_op       <= OP_IDLE;
            col_card_out <= {CARD_W{1'b0}};
            src_sel_r    <= 3'd0;
            dst_sel_r    <= 3'd0;
            src_card_r   <= {CARD_W{1'b0}};
        end else begin
            move_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (move_req) begin
                        move_ready <= 1'b0;
                        if (idx_bad_s) begin
                            state_r   <= ST_DONE;
                            move_done <= 1'b1;
                            move_ok   <= 1'b0;
                            err_code  <= ERR_BAD_IDX;
                            col_op    <= OP_IDLE;
                        end else begin
                            state_r   <= ST_PEEK_SRC;
                            src_sel_r <= src_col;
                            dst_sel_r <= dst_col;
                            col_sel   <= src_col;
                            col_op    <= OP_PEEK;
                        end
                    end else begin
                        move_ready <= 1'b1;
                        col_op     <= OP_IDLE;
                    end
                end
                ST_PEEK_SRC: begin
                    state_r <= ST_PEEK_DST;
                    col_sel <= dst_sel_r;
                    col_op  <= OP_PEEK;
                end
                ST_PEEK_DST: begin
                    state_r    <= ST_CHECK;
                    src_card_r <= col_card_in;
                    col_op     <= OP_IDLE;
                end
                ST_CHECK: begin
                    if (rule_legal_s) begin
                        state_r <= ST_POP_SRC;
                        col_sel <= src_sel_r;
                        col_op  <= OP_POP;
                    end else begin
                        state_r   <= ST_DONE;
                        move_done <= 1'b1;
                        move_ok   <= 1'b0;
                        err_code  <= rule_err_s;
                        col_op    <= OP_IDLE;
                    end
                end
                ST_POP_SRC: begin
                    state_r      <= ST_PUSH_DST;
                    col_sel      <= dst_sel_r;
                    col_op       <= OP_PUSH;
                    col_card_out <= src_card_r;
                end
                ST_PUSH_DST: begin
                    state_r   <= ST_DONE;
                    col_op    <= OP_IDLE;
                    move_done <= 1'b1;
                    move_ok   <= 1'b1;
                    err_code  <= ERR_OK;
                end
                ST_DONE: begin
                    state_r    <= ST_IDLE;
                    move_ready <= 1'b1;
                    col_op     <= OP_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    move_ready <= 1'b1;
                    col_op     <= OP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_solitaire_move_ctrl.sv
// Scoreboard bench for solitaire_move_ctrl: the bench plays the column array,
// predicts each move's outcome from the game rules and checks it at move_done.
module tb_solitaire_move_ctrl;

    logic       clk;
    logic       rst;
    logic       move_req;
    logic [2:0] src_col;
    logic [2:0] dst_col;
    logic       move_ready;
    logic       move_done;
    logic       move_ok;
    logic [1:0] err_code;
    logic [2:0] col_sel;
    logic [1:0] col_op;
    logic [5:0] col_card_out;
    logic [5:0] col_card_in;

    solitaire_move_ctrl #(.NUM_COLS(7)) dut (
        .clk          (clk),
        .rst          (rst),
        .move_req     (move_req),
        .src_col      (src_col),
        .dst_col      (dst_col),
        .move_ready   (move_ready),
        .move_done    (move_done),
        .move_ok      (move_ok),
        .err_code     (err_code),
        .col_sel      (col_sel),
        .col_op       (col_op),
        .col_card_out (col_card_out),
        .col_card_in  (col_card_in)
    );

    typedef struct {
        int ok;
        int err;
        int lat;
        int src;
        int dst;
        int card;
        int acc;
    } exp_t;

    exp_t       sb_q[$];
    logic [5:0] top_card [8];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    int         pops = 0;
    int         pushes = 0;
    int         pop_col = 0;
    int         push_col = 0;
    int         push_card = 0;
    int         done_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference outcome straight from the game rules.
    function automatic void ref_model(input int s, input int d, input int sc, input int dc,
                                      output int err);
        int sr, dr;
        sr = sc % 16;
        dr = dc % 16;
        if (s >= 7 || d >= 7 || s == d) err = 3;
        else if (sr == 15) err = 1;
        else begin
`ifdef SOLITAIRE_FREE_PLACE_EN
            err = 0;
`else
            if (dr == 15) err = (sr == 13) ? 0 : 2;
            else if (sr + 1 == dr && (sc / 32) != (dc / 32)) err = 0;
            else err = 2;
`endif
        end
    endfunction

    // Column array model: answers peeks one cycle later, logs pops/pushes.
    initial begin
        logic [1:0] op;
        logic [2:0] sel;
        logic [5:0] card;
        col_card_in = 6'd0;
        forever begin
            @(negedge clk);
            op   = col_op;
            sel  = col_sel;
            card = col_card_out;
            @(posedge clk);
            #1;
            if (op == 2'b01) col_card_in = top_card[sel];
            if (op == 2'b11) begin pops++; pop_col = int'(sel); end
            if (op == 2'b10) begin pushes++; push_col = int'(sel); push_card = int'(card); end
        end
    end

    // Monitor: compares every move_done against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && move_done) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    check("move_ok", int'(move_ok), e.ok);
                    check("err_code", int'(err_code), e.err);
                    check("latency", cyc - e.acc + 1, e.lat);
                    check("ready_busy", int'(move_ready), 0);
                    check("pops", pops, e.ok);
                    check("pushes", pushes, e.ok);
                    if (e.ok == 1) begin
                        check("pop_col", pop_col, e.src);
                        check("push_col", push_col, e.dst);
                        check("push_card", push_card, e.card);
                    end
                end
                pops = 0;
                pushes = 0;
                @(negedge clk);
                if (!rst) check("ready_after_done", int'(move_ready), 1);
            end
        end
    end

    task automatic wait_ready();
        for (int k = 0; k < 40 && !move_ready; k++) @(negedge clk);
        check("ready_timeout", int'(move_ready), 1);
    endtask

    task automatic do_move(input int s, input int d, input int sc, input int dc, input bit hold);
        exp_t e;
        int   err;
        @(negedge clk);
        wait_ready();
        top_card[s] = 6'(sc);
        if (d != s) top_card[d] = 6'(dc);
        ref_model(s, d, sc, dc, err);
        e.err  = err;
        e.ok   = (err == 0) ? 1 : 0;
        e.lat  = (err == 3) ? 1 : ((err == 0) ? 6 : 4);
        e.src  = s;
        e.dst  = d;
        e.card = sc;
        move_req = 1'b1;
        src_col  = 3'(s);
        dst_col  = 3'(d);
        @(posedge clk);
        #1;
        e.acc = cyc;
        sb_q.push_back(e);
        if (hold) begin
            src_col = 3'($urandom_range(0, 7));
            dst_col = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
        end
        move_req = 1'b0;
    endtask

    function automatic int rand_card();
        int suit;
        suit = int'($urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) return suit * 16 + 15;
        return suit * 16 + int'($urandom_range(1, 13));
    endfunction

    initial begin
        int s, d, sc, dc, osuit;
        rst = 1'b1;
        move_req = 1'b0;
        src_col = 3'd0;
        dst_col = 3'd0;
        for (int i = 0; i < 8; i++) top_card[i] = 6'h0F;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", int'(move_ready), 1);
        check("rst_done", int'(move_done), 0);
        check("rst_ok", int'(move_ok), 0);
        check("rst_err", int'(err_code), 0);
        check("rst_sel", int'(col_sel), 0);
        check("rst_op", int'(col_op), 0);
        check("rst_card_out", int'(col_card_out), 0);
        rst = 1'b0;

        // Directed cases
        do_move(0, 1, 6'h26, 6'h07, 1'b0);
        do_move(2, 3, 6'h36, 6'h27, 1'b0);
        do_move(4, 5, 6'h1D, 6'h0F, 1'b0);
        do_move(4, 5, 6'h1C, 6'h0F, 1'b0);
        do_move(0, 1, 6'h3F, 6'h07, 1'b0);
        do_move(2, 2, 6'h26, 6'h26, 1'b0);
        do_move(7, 1, 6'h26, 6'h07, 1'b0);
        do_move(1, 7, 6'h26, 6'h07, 1'b1);
        do_move(3, 6, 6'h0C, 6'h2D, 1'b1);

        // Randomised moves, biased towards legal placements
        for (int n = 0; n < 300; n++) begin
            s  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 6));
            d  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 6));
            sc = rand_card();
            dc = rand_card();
            if ($urandom_range(0, 2) == 0 && (sc % 16) < 13) begin
                osuit = ((1 - sc / 32) * 2) + int'($urandom_range(0, 1));
                dc = osuit * 16 + (sc % 16) + 1;
            end
            do_move(s, d, sc, dc, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a legal move, during the pop
        @(negedge clk);
        wait_ready();
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
        top_card[0] = 6'h26;
        top_card[1] = 6'h07;
        move_req = 1'b1;
        src_col  = 3'd0;
        dst_col  = 3'd1;
        @(posedge clk);
        #1;
        move_req = 1'b0;
        for (int k = 0; k < 20 && col_op != 2'b11; k++) @(negedge clk);
        check("reach_pop", int'(col_op), 3);
        begin
            int dc0;
            dc0 = done_cnt;
            rst = 1'b1;
            @(posedge clk);
            #1;
            check("rst_mid_op", int'(col_op), 0);
            check("rst_mid_ready", int'(move_ready), 1);
            check("rst_mid_done", int'(move_done), 0);
            @(negedge clk);
            rst = 1'b0;
            repeat (10) @(negedge clk);
            check("rst_mid_no_push", pushes, 0);
            check("rst_mid_no_done", done_cnt, dc0);
            pops = 0;
            pushes = 0;
        end

        // A normal move still completes after the abort
        do_move(0, 1, 6'h26, 6'h07, 1'b0);
        for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(negedge clk);
        check("drain", sb_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/solitaire_move_ctrl.md
# solitaire_move_ctrl

Sequencer that executes a single-card move between two solitaire tableau columns over a shared column-access bus. It reads the top card of the source and destination columns and checks legality (descending rank, alternating colour, King onto empty). A legal move is committed with a pop from the source followed by a push to the destination; an illegal move is rejected with an error code. It sits between the game-control logic and the array of tableau column stacks, and is the only master of the column bus.

## Interface
- NUM_COLS, 7, number of tableau columns addressed (col index width fixed at 3 bits)
- CARD_W, 6, card width: [5:4] suit, [3:0] rank
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- move_req  in  1  start a move; sampled only when move_ready=1
- src_col  in  3  source column index, sampled with move_req
- dst_col  in  3  destination column index, sampled with move_req
- move_ready  out  1  controller idle, can accept move_req
- move_done  out  1  one-cycle pulse, move finished (committed or rejected)
- move_ok  out  1  valid with move_done: 1 = committed
- err_code  out  2  valid with move_done: 00 ok, 01 source empty, 10 illegal placement, 11 bad index
- col_sel  out  3  column addressed on the bus
- col_op  out  2  00 idle, 01 peek top, 11 pop top, 10 push col_card_out
- col_card_out  out  6  card to push
- col_card_in  in  6  top card of col_sel, valid the cycle after a peek; rank 4'hF = empty column

## Operation
- Card encoding: suit 00 hearts, 01 diamonds (red), 10 clubs, 11 spades (black); colour = suit[1]; rank 1 (A) to 13 (K); 4'hF = empty.
- States: IDLE, PEEK_SRC, PEEK_DST, CHECK, POP_SRC, PUSH_DST, DONE.
- IDLE: move_ready=1. On move_req:
  - src_col or dst_col ≥ NUM_COLS, or src_col==dst_col: latch err 11, go to DONE.
  - Otherwise latch the indices and go to PEEK_SRC.
- PEEK_SRC: col_sel=src, col_op=01.
- PEEK_DST: capture col_card_in as src_card; col_sel=dst, col_op=01.
- CHECK: capture dst_card, col_op=00, then evaluate in this priority order:
  - src rank==F: err 01.
  - dst rank==F: legal iff src rank==13; otherwise err 10.
  - dst non-empty: legal iff src rank == dst rank−1 and src colour ≠ dst colour; otherwise err 10.
  - Legal goes to POP_SRC; rejected goes to DONE.
- POP_SRC: col_sel=src, col_op=11.
- PUSH_DST: col_sel=dst, col_op=10, col_card_out=src_card.
- DONE: move_done=1; move_ok=(err==00); return to IDLE.
- The block never pushes without a preceding pop in the same move. A rejected move issues no pop and no push.

## Timing
- Reset values: state IDLE, move_ready=1, move_done=0, move_ok=0, err_code=00, col_sel=0, col_op=00, col_card_out=0.
- Cycle 0 = the edge on which move_req is accepted.
- Legal move: PEEK_SRC c1, PEEK_DST c2, CHECK c3, POP_SRC c4, PUSH_DST c5, move_done c6.
- Rejected after check: move_done c4.
- Bad index: move_done c1.
- move_ready=0 from c1 until the cycle after move_done. move_req while busy is ignored, not queued.
- move_ok and err_code hold their values until the next accepted move.
- rst mid-move: col_op=00 on the next cycle and the move is aborted with no push. A pop issued before rst is not undone; the game layer owns recovery.

## Configuration
- SOLITAIRE_FREE_PLACE_EN defined: the rank and colour rules are bypassed. Any non-empty source onto any destination is legal; err 01 and err 11 still apply. Used for debug and board setup.
- Undefined: full rules as above.

## Structure
- Package solitaire_pkg holds:
  - card field positions, RANK_EMPTY=4'hF, RANK_KING=4'd13
  - col_op encodings (OP_IDLE/PEEK/POP/PUSH)
  - err_code constants
  - FSM state enum
- Sub-module card_rule_check: combinational (src_card, dst_card) → legal, err. It holds the SOLITAIRE_FREE_PLACE_EN switch.

## Test plan
- src top 6'b10_0110 (6♣), dst top 6'b00_0111 (7♥) → pop src at c4, push 6'h26 to dst at c5, move_done c6, ok=1, err 00.
- src 6'b11_0110 (6♠), dst 6'b10_0111 (7♣) → move_done c4, ok=0, err 10, no pop/push. With SOLITAIRE_FREE_PLACE_EN defined → committed, ok=1.
- dst empty (rank F), src 6'b01_1101 (K♦) → committed. Same with src 6'b01_1100 (Q♦) → err 10.
- src empty (6'h3F) → err 01 at c4; col_op never 11 or 10.
- src_col=dst_col=2 → move_done c1, err 11. src_col=7 → err 11. move_req held during a busy move → ignored.
- rst asserted during POP_SRC → col_op=00 next cycle, move_ready=1, no push issued, move_done not asserted.
